// File: rtl/spu_pkg.sv
// spu_pkg: shared types and constants for the SPU issue router.
//   instr_t      - one decoded instruction as carried through the router
//   PAIR/HOLD    - router state encodings
//   SPU_*_W      - default field widths (REG_W default is SPU_REG_W)
package spu_pkg;

    localparam int unsigned SPU_REG_W  = 7;
    localparam int unsigned SPU_IMM_W  = 26;
    localparam int unsigned SPU_LAT_W  = 4;
    localparam int unsigned SPU_UNIT_W = 3;
    localparam int unsigned SPU_USE_W  = 3;

    // regs = {RA,RB,RC,RT}; srcs = {useRA,useRB,useRC}
    typedef struct packed {
        logic [4*SPU_REG_W-1:0] regs;
        logic [SPU_IMM_W-1:0]   imm;
        logic [SPU_LAT_W-1:0]   lat;
        logic [SPU_UNIT_W-1:0]  unit;
        logic                   we;
        logic                   even;
        logic [SPU_USE_W-1:0]   srcs;
    } instr_t;

    localparam logic [0:0] PAIR = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

endpackage

// File: rtl/spu_pair_hazard.sv
// spu_pair_hazard: combinational hazard detect for an in-order instruction pair.
//   inputs : slot valids, pipe selects, slot0 write enable, slot1 source enables,
//            both register tuples {RA,RB,RC,RT}
//   outputs: conflict (both need the same pipe), dep (slot1 reads slot0 RT),
//            split (pair must issue over two cycles)
module spu_pair_hazard #(
    parameter int unsigned REG_W = spu_pkg::SPU_REG_W
) (
    input  logic               s0_valid,
    input  logic               s1_valid,
    input  logic               s0_even,
    input  logic               s1_even,
    input  logic               s0_we,
    input  logic [2:0]         s1_use,
    input  logic [4*REG_W-1:0] s0_regs,
    input  logic [4*REG_W-1:0] s1_regs,
    output logic               conflict,
    output logic               dep,
    output logic               split
);

    logic [REG_W-1:0] s0_rt;
    logic [REG_W-1:0] s1_ra;
    logic [REG_W-1:0] s1_rb;
    logic [REG_W-1:0] s1_rc;
    logic [REG_W-1:0] s1_rt_unused;
    logic [3*REG_W-1:0] s0_src_unused;

    assign {s0_src_unused, s0_rt}       = s0_regs;
    assign {s1_ra, s1_rb, s1_rc, s1_rt_unused} = s1_regs;

    logic src_hit;
    assign src_hit = (s1_use[2] && (s1_ra == s0_rt)) ||
                     (s1_use[1] && (s1_rb == s0_rt)) ||
                     (s1_use[0] && (s1_rc == s0_rt));

    assign dep      = s0_valid && s1_valid && s0_we && src_hit;
    assign conflict = s0_valid && s1_valid && (s0_even == s1_even);
    assign split    = dep || conflict;

endmodule

// File: rtl/spu_issue_router.sv
// spu_issue_router: registered dual-issue steering of a decode pair onto the
// even/odd SPU pipe issue registers.
//   clk, reset        - clock, synchronous active-high reset
//   in_valid/in_ready - decode pair handshake (in_ready is combinational)
//   stall, flush      - downstream freeze / discard
//   s0_*, s1_*        - slot0 (older) and slot1 (younger) instruction fields
//   ev_*, od_*        - even/odd pipe issue registers
//   ev_older          - both pipes valid and the even one holds the older instruction
//   dual_cnt          - saturating count of pairs issued in one cycle
//   split_cnt         - saturating count of pairs split over two cycles
// Field widths other than CNT_W must match the spu_pkg defaults.
module spu_issue_router
    import spu_pkg::*;
#(
    parameter int unsigned REG_W  = SPU_REG_W,
    parameter int unsigned IMM_W  = SPU_IMM_W,
    parameter int unsigned LAT_W  = SPU_LAT_W,
    parameter int unsigned UNIT_W = SPU_UNIT_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stall,
    input  logic               flush,
    input  logic               s0_valid,
    input  logic               s1_valid,
    input  logic               s0_even,
    input  logic               s1_even,
    input  logic               s0_we,
    input  logic               s1_we,
    input  logic [2:0]         s0_use,
    input  logic [2:0]         s1_use,
    input  logic [4*REG_W-1:0] s0_regs,
    input  logic [4*REG_W-1:0] s1_regs,
    input  logic [IMM_W-1:0]   s0_imm,
    input  logic [IMM_W-1:0]   s1_imm,
    input  logic [LAT_W-1:0]   s0_lat,
    input  logic [LAT_W-1:0]   s1_lat,
    input  logic [UNIT_W-1:0]  s0_unit,
    input  logic [UNIT_W-1:0]  s1_unit,
    output logic               ev_valid,
    output logic               od_valid,
    output logic [4*REG_W-1:0] ev_regs,
    output logic [4*REG_W-1:0] od_regs,
    output logic [IMM_W-1:0]   ev_imm,
    output logic [IMM_W-1:0]   od_imm,
    output logic [LAT_W-1:0]   ev_lat,
    output logic [LAT_W-1:0]   od_lat,
    output logic [UNIT_W-1:0]  ev_unit,
    output logic [UNIT_W-1:0]  od_unit,
    output logic               ev_we,
    output logic               od_we,
    output logic               ev_older,
    output logic [CNT_W-1:0]   dual_cnt,
    output logic [CNT_W-1:0]   split_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [0:0]       state_q, state_d;
    instr_t           hold_q, hold_d;
    instr_t           ev_q, ev_d, od_q, od_d;
    logic             ev_valid_q, ev_valid_d, od_valid_q, od_valid_d;
    logic             ev_older_q, ev_older_d;
    logic [CNT_W-1:0] dual_q, dual_d, split_q, split_d;
    instr_t           i0, i1;
    logic             conflict, dep, split;

    spu_pair_hazard #(
        .REG_W (REG_W)
    ) u_hazard (
        .s0_valid (s0_valid),
        .s1_valid (s1_valid),
        .s0_even  (s0_even),
        .s1_even  (s1_even),
        .s0_we    (s0_we),
        .s1_use   (s1_use),
        .s0_regs  (s0_regs),
        .s1_regs  (s1_regs),
        .conflict (conflict),
        .dep      (dep),
        .split    (split)
    );

    assign in_ready = (state_q == PAIR) && !stall;

    always_comb begin
        i0 = '{regs: s0_regs, imm: s0_imm, lat: s0_lat, unit: s0_unit,
               we: s0_we, even: s0_even, srcs: s0_use};
        i1 = '{regs: s1_regs, imm: s1_imm, lat: s1_lat, unit: s1_unit,
               we: s1_we, even: s1_even, srcs: s1_use};

        state_d    = state_q;
        hold_d     = hold_q;
        ev_d       = ev_q;
        od_d       = od_q;
        ev_valid_d = ev_valid_q;
        od_valid_d = od_valid_q;
        ev_older_d = ev_older_q;
        dual_d     = dual_q;
        split_d    = split_q;

        if (flush) begin
            // Wins over stall and over any acceptance this cycle.
            ev_valid_d = 1'b0;
            od_valid_d = 1'b0;
            ev_older_d = 1'b0;
            state_d    = PAIR;
            hold_d     = '0;
        end else if (!stall) begin
            // Every non-stalled cycle reloads the valids so nothing issues twice.
            ev_valid_d = 1'b0;
            od_valid_d = 1'b0;
            ev_older_d = 1'b0;
            if (state_q == HOLD) begin
                if (hold_q.even) begin
                    ev_valid_d = 1'b1;
                    ev_d       = hold_q;
                end else begin
                    od_valid_d = 1'b1;
                    od_d       = hold_q;
                end
                hold_d  = '0;
                state_d = PAIR;
            end else if (in_valid) begin
                if (s0_valid) begin
                    if (i0.even) begin
                        ev_valid_d = 1'b1;
                        ev_d       = i0;
                    end else begin
                        od_valid_d = 1'b1;
                        od_d       = i0;
                    end
                end
                if (split) begin
                    hold_d  = i1;
                    state_d = HOLD;
                    split_d = sat_inc(split_q);
                end else begin
                    if (s1_valid) begin
                        if (i1.even) begin
                            ev_valid_d = 1'b1;
                            ev_d       = i1;
                        end else begin
                            od_valid_d = 1'b1;
                            od_d       = i1;
                        end
                    end
                    if (s0_valid && s1_valid) begin
                        ev_older_d = s0_even;
                        dual_d     = sat_inc(dual_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PAIR;
            hold_q     <= '0;
            ev_q       <= '0;
            od_q       <= '0;
            ev_valid_q <= 1'b0;
            od_valid_q <= 1'b0;
            ev_older_q <= 1'b0;
            dual_q     <= '0;
            split_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            ev_q       <= ev_d;
            od_q       <= od_d;
            ev_valid_q <= ev_valid_d;
            od_valid_q <= od_valid_d;
            ev_older_q <= ev_older_d;
            dual_q     <= dual_d;
            split_q    <= split_d;
        end
    end

    assign ev_valid  = ev_valid_q;
    assign od_valid  = od_valid_q;
    assign ev_regs   = ev_q.regs;
    assign od_regs   = od_q.regs;
    assign ev_imm    = ev_q.imm;
    assign od_imm    = od_q.imm;
    assign ev_lat    = ev_q.lat;
    assign od_lat    = od_q.lat;
    assign ev_unit   = ev_q.unit;
    assign od_unit   = od_q.unit;
    assign ev_we     = ev_q.we;
    assign od_we     = od_q.we;
    assign ev_older  = ev_older_q;
    assign dual_cnt  = dual_q;
    assign split_cnt = split_q;

    // Pipe select and source enables are not forwarded downstream.
    logic unused_fields;
    assign unused_fields = ^{ev_q.srcs, ev_q.even, od_q.srcs, od_q.even, hold_q.srcs};

endmodule

// File: doc/spu_issue_router.md
Name: spu_issue_router

Overview:
- Registered dual-issue router between decode and the even/odd SPU pipes.
- Each cycle it takes an in-order instruction pair (slot0 older, slot1 younger) and steers each instruction to the even or odd pipe issue register.
- It splits the pair over two cycles on a structural conflict (both instructions need the same pipe) or an intra-pair RAW dependency.
- It honours downstream stall and flush, and keeps saturating dual-issue/split statistics.

Parameters:
- REG_W, 7, register address width (128-entry file)
- IMM_W, 26, widest immediate field carried
- LAT_W, 4, latency field width
- UNIT_W, 3, execution unit ID width
- CNT_W, 16, statistics counter width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  decode pair valid
- in_ready  output  1  pair accepted when in_valid&&in_ready; combinational = (state==PAIR)&&!stall
- stall  input  1  downstream stall; freezes issue registers
- flush  input  1  discard parked and issued instructions
- s0_valid/s1_valid  input  1 each  slot occupied
- s0_even/s1_even  input  1 each  1=even pipe, 0=odd pipe
- s0_we/s1_we  input  1 each  slot writes RT
- s0_use/s1_use  input  3 each  {useRA,useRB,useRC}
- s0_regs/s1_regs  input  4*REG_W each  {RA,RB,RC,RT}
- s0_imm/s1_imm  input  IMM_W each  immediate
- s0_lat/s1_lat  input  LAT_W each  latency
- s0_unit/s1_unit  input  UNIT_W each  unit ID
- ev_valid/od_valid  output  1 each  pipe issue valid
- ev_regs/od_regs, ev_imm/od_imm, ev_lat/od_lat, ev_unit/od_unit, ev_we/od_we  output  as inputs  issued fields
- ev_older  output  1  both pipes valid and even instruction is the older one
- dual_cnt  output  CNT_W  saturating count of pairs issued in one cycle
- split_cnt  output  CNT_W  saturating count of split pairs

Behaviour:
- Reset (synchronous): state=PAIR; all issue valids, fields and ev_older 0; hold register empty; counters 0. in_ready follows its combinational rule and is 1 one cycle after reset deasserts if stall=0.
- Latency: accepted instruction appears on pipe outputs the cycle after acceptance. Outputs are registers only.
- dep = s0_valid && s1_valid && s0_we && any enabled s1 source (use bit set) equals s0 RT.
- conflict = s0_valid && s1_valid && (s0_even==s1_even).
- Accept, no conflict and no dep: issue each valid slot to its pipe. The other pipe gets valid=0. ev_older is set per slot order. dual_cnt++ only if both slots are valid.
- Accept, conflict or dep: issue slot0 only and park slot1 in the hold register. Go to HOLD. split_cnt++.
- HOLD: in_ready=0. On the next cycle with !stall, issue the held instruction to its pipe; the other pipe valid=0. Return to PAIR.
- Slot1 never issues before, or with, slot0 when dep holds. Order is strict.
- A pair with only s1_valid issues as a single instruction.
- in_valid with both slot valids 0 is accepted and issues nothing.
- stall=1: issue registers, state and hold register all hold, and no acceptance. A pipe's valid does not reassert a second time for the same instruction; downstream samples only while !stall.
- flush=1: next cycle all valids 0, hold emptied, state=PAIR. Flush overrides stall and any same-cycle acceptance. Counters are unaffected.
- Reset overrides flush.
- Counters saturate at 2^CNT_W-1 and do not wrap.

Decomposition:
- Shared package spu_pkg holds:
  - the instr_t struct {regs,imm,lat,unit,we,even,use} and its widths
  - the state enum {PAIR,HOLD}
  - the REG_W default
- One natural sub-module: spu_pair_hazard (combinational conflict/dep detect). Steering, hold register and counters stay in the top.

Test Plan:
- Even/odd pair: s0 even RT=5, s1 odd RA=9 -> next cycle ev_valid=od_valid=1, ev_older=1, dual_cnt=1, in_ready stays 1.
- Structural conflict: both even -> cycle1 ev=slot0, od_valid=0, in_ready=0. Cycle2 ev=slot1, od_valid=0. split_cnt=1.
- RAW dependency: s0 even we RT=12, s1 odd use RA=1 with RA=12 -> split over 2 cycles. The same case with useRA=0 dual-issues.
- Stall in HOLD: stall for 3 cycles after the split -> outputs frozen, in_ready=0. Held instruction issues the cycle after stall drops.
- Flush with stall=1 during HOLD -> next cycle both valids 0, state PAIR, in_ready=1 once stall drops. The held instruction is never issued.
- Saturation: CNT_W=2, 5 dual pairs -> dual_cnt=3. Reset mid-HOLD -> all outputs 0 next cycle.
